addsub_op_stream: RTL

- Sequential front/back stage for the team's 4-bit signed adder/subtractor datapath.
- Accepts operand commands (a, b, add/sub) over a valid/ready handshake and buffers them in a small FIFO.
- Computes the signed (W+1)-bit sum or difference, then presents it in a registered output with its own valid/ready handshake.
- Also drives overflow and operation-count status.

---
 rtl/addsub_pkg.sv | 10 +
 rtl/addsub_op_stream_if.sv | 20 ++
 rtl/addsub_core.sv | 18 +
 rtl/addsub_op_stream.sv | 98 +++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared operand width, output-stage states and command layout for addsub_op_stream.
package addsub_pkg;
    localparam int DEF_W = 4;
    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;
    typedef struct packed {
        logic [DEF_W-1:0] a;
        logic [DEF_W-1:0] b;
        logic             sub;
    } cmd_t;
endpackage

// File: rtl/addsub_op_stream_if.sv
// addsub_op_stream_if: command and result handshakes of addsub_op_stream.
interface addsub_op_stream_if #(parameter int W = addsub_pkg::DEF_W);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   out_result;
    logic         out_ovf;
    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_result, out_ovf
    );
    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_result, out_ovf
    );
endinterface

// File: rtl/addsub_core.sv
// addsub_core: combinational signed W-bit add/sub with an exact W+1-bit result and W-bit overflow flag.
module addsub_core #(
    parameter int W = addsub_pkg::DEF_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W:0]   sum,
    output logic         ovf
);
    logic [W:0] ax;
    logic [W:0] bx;
    // subtraction reuses the adder: invert b and inject sub as carry-in
    assign ax  = {a[W-1], a};
    assign bx  = {b[W-1], b} ^ {(W+1){sub}};
    assign sum = ax + bx + {{W{1'b0}}, sub};
    assign ovf = sum[W] ^ sum[W-1];
endmodule

// File: rtl/addsub_op_stream.sv
// addsub_op_stream: FIFO-buffered signed add/sub stream with registered, handshaked results.
// Optional ADDSUB_STICKY_OVF_EN adds ovf_clr / sticky_ovf.
module addsub_op_stream
    import addsub_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    addsub_op_stream_if.slave        bus,
`ifdef ADDSUB_STICKY_OVF_EN
    input  logic                     ovf_clr,
    output logic                     sticky_ovf,
`endif
    output logic                     busy,
    output logic [7:0]               op_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

    cmd_t         mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]  cnt;
    logic         full, empty, push, pop, take;
    logic [W:0]   sum, result;
    logic         sum_ovf, ovf;
    cmd_t         head;
    out_state_t   state, nstate;

    assign full  = cnt == CAP;
    assign empty = cnt == '0;
    assign push  = bus.in_valid && !full;
    assign pop   = !empty && (!bus.out_valid || bus.out_ready);
    assign take  = bus.out_valid && bus.out_ready;
    assign head  = mem[rp];

    assign bus.in_ready   = !full;
    assign bus.out_valid  = state == OUT_FULL;
    assign bus.out_result = result;
    assign bus.out_ovf    = ovf;
    assign busy           = !empty || bus.out_valid;

    addsub_core #(.W(W)) u_core (
        .a   (head.a),
        .b   (head.b),
        .sub (head.sub),
        .sum (sum),
        .ovf (sum_ovf)
    );

    // storage needs no reset: only entries between rp and wp are ever read
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= '{a: bus.in_a, b: bus.in_b, sub: bus.in_sub};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_comb begin
        nstate = state;
        nstate = pop ? OUT_FULL : (bus.out_ready ? OUT_EMPTY : state);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OUT_EMPTY;
            result   <= '0;
            ovf      <= 1'b0;
            op_count <= '0;
        end else begin
            state <= nstate;
            if (pop) begin
                result <= sum;
                ovf    <= sum_ovf;
            end
            if (take) op_count <= op_count + 8'd1;
        end
    end

`ifdef ADDSUB_STICKY_OVF_EN
    // set beats clear when both happen in one cycle
    always_ff @(posedge clk) begin
        if (rst) sticky_ovf <= 1'b0;
        else if (take && ovf) sticky_ovf <= 1'b1;
        else if (ovf_clr) sticky_ovf <= 1'b0;
    end
`endif
endmodule
